seq_multiplier_n: RTL and testbench

SEQ_MULTIPLIER_N -- requirements
Module: seq_multiplier_n

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_datapath.sv | 96 +++++++++
 rtl/seq_multiplier_n.sv | 117 +++++++++++
 tb/tb_seq_multiplier_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   - mult_state_e   : controller states (IDLE / RUN / DONE)
//   - MULT_WIDTH_MIN : smallest supported operand width
//   - MULT_WIDTH_MAX : largest supported operand width
// No ports; imported by seq_multiplier_n and mult_datapath.
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int MULT_WIDTH_MIN = 2;
    localparam int MULT_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_datapath.sv
// ----------------------------------------------------------------------------
// mult_datapath
// Operand registers and one-iteration-per-cycle arithmetic for the sequential
// multiplier. S holds the multiplicand, {X,A,B} is the shifting partial
// product / multiplier register.
//
// Configuration macro: MULT_SIGNED_EN
//   defined   : two's complement operation, sign-extended adds, subtract on the
//               final iteration, arithmetic right shift (X replicated).
//   undefined : unsigned operation, carry into X, logical shift, no subtractor.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset_n    in   asynchronous active-low reset, clears all registers
//   load_i     in   capture operands and clear A / X
//   step_i     in   perform one add-and-shift iteration
//   last_i     in   final iteration flag (signed build only)
//   mcand_i    in   multiplicand  [WIDTH-1:0]
//   mplier_i   in   multiplier    [WIDTH-1:0]
//   prodNext_o out  {A,B} as it will be after the current iteration's shift
// ----------------------------------------------------------------------------
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               load_i,
    input  logic               step_i,
`ifdef MULT_SIGNED_EN
    input  logic               last_i,
`endif
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prodNext_o
);

    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             x_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             x_d;
    logic [WIDTH:0]   sum;

    // One iteration: conditionally add (or, signed final step, subtract) S
    // into {X,A} at WIDTH+1 bits, then shift {X,A,B} right by one. The bit
    // shifted into the top of X is the sign in the signed build and 0 otherwise.
    always_comb begin
        sum = {x_q, a_q};
        if (b_q[0]) begin
`ifdef MULT_SIGNED_EN
            if (last_i) begin
                sum = {a_q[WIDTH-1], a_q} - {s_q[WIDTH-1], s_q};
            end else begin
                sum = {a_q[WIDTH-1], a_q} + {s_q[WIDTH-1], s_q};
            end
`else
            sum = {1'b0, a_q} + {1'b0, s_q};
`endif
        end
`ifdef MULT_SIGNED_EN
        x_d = sum[WIDTH];
`else
        x_d = 1'b0;
`endif
        a_d = sum[WIDTH:1];
        b_d = {sum[0], b_q[WIDTH-1:1]};
    end

    assign prodNext_o = {a_d, b_d};

    // Load clears the accumulator so an aborted or previous operation leaves
    // no residue; otherwise registers advance only while stepping.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s_q <= '0;
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else if (load_i) begin
            s_q <= mcand_i;
            a_q <= '0;
            b_q <= mplier_i;
            x_q <= 1'b0;
        end else if (step_i) begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/seq_multiplier_n.sv
// ----------------------------------------------------------------------------
// seq_multiplier_n
// Sequential WIDTH x WIDTH multiplier, one iteration per clock. A start seen in
// IDLE captures the operands; WIDTH RUN cycles later the result is loaded into
// the product register and done pulses for one cycle in DONE.
//
// Configuration macro: MULT_SIGNED_EN (two's complement when defined,
// unsigned otherwise; see mult_datapath).
//
// Ports
//   Clk      in   clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   start    in   begin a multiplication (only honoured in IDLE)
//   mcand    in   multiplicand [WIDTH-1:0]
//   mplier   in   multiplier   [WIDTH-1:0]
//   busy     out  high in RUN and DONE
//   done     out  one-cycle completion pulse (DONE state)
//   product  out  result [2*WIDTH-1:0], held until the next completion
// ----------------------------------------------------------------------------
module seq_multiplier_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CntW = $clog2(WIDTH + 1);

    if (WIDTH < MULT_WIDTH_MIN || WIDTH > MULT_WIDTH_MAX) begin : gBadWidth
        $error("seq_multiplier_n: WIDTH out of supported range");
    end

    mult_state_e          state_q;
    logic [CntW-1:0]      cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 loadOps;
    logic                 stepOp;
    logic                 lastIter;
    logic [2*WIDTH-1:0]   prodNext;

    assign loadOps  = (state_q == IDLE) && start;
    assign stepOp   = (state_q == RUN);
    assign lastIter = (cnt_q == CntW'(WIDTH - 1));

    mult_datapath #(
        .WIDTH      (WIDTH)
    ) uDatapath (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load_i     (loadOps),
        .step_i     (stepOp),
`ifdef MULT_SIGNED_EN
        .last_i     (lastIter),
`endif
        .mcand_i    (mcand),
        .mplier_i   (mplier),
        .prodNext_o (prodNext)
    );

    // Controller: busy/done are registered alongside the state so they are
    // glitch-free. The product register is written only on the RUN->DONE edge,
    // taking the post-shift {A,B} of the final iteration.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (lastIter) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        product_q <= prodNext;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier_n
// Self-checking bench for seq_multiplier_n at WIDTH=8. Honours MULT_SIGNED_EN
// so the same file checks either build against a plain-arithmetic model.
// ----------------------------------------------------------------------------
module tb_seq_multiplier_n;

    logic        clock;
    logic        resetN;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] lastProduct;

`ifdef MULT_SIGNED_EN
    localparam logic [15:0] Exp07xFD = 16'hFFEB;
    localparam logic [15:0] ExpFFxFF = 16'h0001;
`else
    localparam logic [15:0] Exp07xFD = 16'h06EB;
    localparam logic [15:0] ExpFFxFF = 16'hFE01;
`endif

    seq_multiplier_n #(
        .WIDTH   (8)
    ) dut (
        .Clk     (clock),
        .Reset_n (resetN),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // 10-unit clock; stimulus and sampling happen on the falling edge
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference product straight from integer arithmetic
    function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SIGNED_EN
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
`else
        return 16'(int'(a) * int'(b));
`endif
    endfunction

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Run one multiplication, scribbling on start/operands while busy (must be
    // ignored, including in the DONE cycle), and check latency, busy length,
    // product hold and the final result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expected, input string tag);
        int cycles;
        int busyCycles;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        cycles = 0;
        busyCycles = 0;
        do begin
            @(negedge clock);
            cycles++;
            if (busy) busyCycles++;
            if (!done) begin
                checkOutput({tag, "_hold"}, 32'(product), 32'(lastProduct));
                start  = 1'($urandom);
                mcand  = 8'($urandom);
                mplier = 8'($urandom);
            end
        end while (!done && cycles < 40);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd9);
        checkOutput({tag, "_product"}, 32'(product), 32'(expected));
        lastProduct = expected;
        start  = 1'b1;
        mcand  = 8'($urandom);
        mplier = 8'($urandom);
        @(negedge clock);
        start = 1'b0;
        checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idleDone"}, 32'(done), 32'd0);
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'd9);
    endtask

    initial begin
        int doneCount;
        int cycle;
        int doneAt[$];
        logic [7:0] ra;
        logic [7:0] rb;

        resetN = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        lastProduct = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        resetN = 1'b1;
        @(negedge clock);

        $display("[TB] directed operand checks");
        applyStimulus(8'h07, 8'hFD, Exp07xFD, "m07xFD");
        applyStimulus(8'hFF, 8'hFF, ExpFFxFF, "mFFxFF");
        applyStimulus(8'h80, 8'h80, 16'h4000, "m80x80");
        applyStimulus(8'h00, 8'hA5, 16'h0000, "m00xA5");

        $display("[TB] start ignored mid-run");
        mcand = 8'h05; mplier = 8'h03; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        start = 1'b1; mcand = 8'hFF; mplier = 8'hFF;
        @(negedge clock);
        start = 1'b0;
        doneCount = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) begin
                doneCount++;
                checkOutput("ignore_product", 32'(product), 32'h000F);
            end
        end
        checkOutput("ignore_doneCount", 32'(doneCount), 32'd1);
        checkOutput("ignore_final", 32'(product), 32'h000F);
        lastProduct = 16'h000F;

        $display("[TB] reset mid-run");
        mcand = 8'h12; mplier = 8'h34; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_product", 32'(product), 32'd0);
        lastProduct = '0;
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        applyStimulus(8'h02, 8'h03, 16'h0006, "afterReset");

        $display("[TB] start held for back-to-back operations");
        mcand = 8'h03; mplier = 8'h04; start = 1'b1;
        cycle = 0;
        while (doneAt.size() < 3 && cycle < 60) begin
            @(negedge clock);
            cycle++;
            if (done) begin
                doneAt.push_back(cycle);
                checkOutput("b2b_product", 32'(product), 32'h000C);
                if (doneAt.size() == 3) start = 1'b0;
            end
        end
        checkOutput("b2b_count", 32'(doneAt.size()), 32'd3);
        if (doneAt.size() == 3) begin
            checkOutput("b2b_gap1", 32'(doneAt[1] - doneAt[0]), 32'd10);
            checkOutput("b2b_gap2", 32'(doneAt[2] - doneAt[1]), 32'd10);
        end
        @(negedge clock);
        checkOutput("b2b_idle", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("b2b_stopped", 32'(busy), 32'd0);
        lastProduct = 16'h000C;

        $display("[TB] randomized operands");
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, refProduct(ra, rb), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
